// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier that retires one multiplier bit per clock, unsigned or signed.
// Define SEQ_MUL_ACC_EN to add the acc input and accumulate products into result_o.
module seq_multiplier #(
    parameter int unsigned A_WIDTH = 24,
    parameter int unsigned B_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       sign_mode_i,
    input  logic [A_WIDTH-1:0]         a_i,
    input  logic [B_WIDTH-1:0]         b_i,
`ifdef SEQ_MUL_ACC_EN
    input  logic                       acc_i,
`endif
    output logic                       busy_o,
    output logic                       done_o,
    output logic [A_WIDTH+B_WIDTH-1:0] result_o
);

    localparam int unsigned PW = A_WIDTH + B_WIDTH;
    localparam int unsigned CW = $clog2(B_WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(B_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    logic               sign_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      prod_q;
    logic [PW-1:0]      result_q;
    logic               busy_q;
    logic               done_q;
`ifdef SEQ_MUL_ACC_EN
    logic               acc_q;
`endif

    logic [PW-1:0] a_ext;
    logic [PW-1:0] addend;
    logic          last;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] result_d;

    always_comb begin
        a_ext  = {{B_WIDTH{sign_q & a_q[A_WIDTH-1]}}, a_q};
        addend = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
        last   = (cnt_q == LastBit);
        // The multiplier MSB carries negative weight in two's complement.
        prod_d = (sign_q && last) ? (prod_q - addend) : (prod_q + addend);
`ifdef SEQ_MUL_ACC_EN
        result_d = acc_q ? (result_q + prod_d) : prod_d;
`else
        result_d = prod_d;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_MUL_ACC_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sign_q  <= sign_mode_i;
`ifdef SEQ_MUL_ACC_EN
                        acc_q   <= acc_i;
`endif
                        cnt_q   <= '0;
                        prod_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last) begin
                        result_q <= result_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (24x8): products, handshake timing, reset mid-run,
// and accumulation when SEQ_MUL_ACC_EN is defined.
module tb_seq_multiplier;

    localparam int unsigned AW = 24;
    localparam int unsigned BW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sign_mode;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          acc;
    logic          busy;
    logic          done;
    logic [31:0]   result;

    int            n_vec;
    int            n_err;
    logic [31:0]   model_res;

    seq_multiplier #(
        .A_WIDTH(AW),
        .B_WIDTH(BW)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .sign_mode_i(sign_mode),
        .a_i        (a),
        .b_i        (b),
`ifdef SEQ_MUL_ACC_EN
        .acc_i      (acc),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive operands so that start is sampled at the next rising edge (E0).
    task automatic launch(input logic [AW-1:0] ta, input logic [BW-1:0] tb, input logic ts,
                          input logic tacc);
        @(negedge clk);
        start     = 1'b1;
        a         = ta;
        b         = tb;
        sign_mode = ts;
        acc       = tacc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_at_e0", 64'(busy), 64'd1);
        check("done_at_e0", 64'(done), 64'd0);
    endtask

    // Follow edges E0+1 .. E0+BW; optionally poke start with junk operands at edge E0+poke.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int poke);
        for (int k = 1; k <= int'(BW); k++) begin
            if (k == poke) begin
                @(negedge clk);
                start     = 1'b1;
                a         = 24'h00007F;
                b         = 8'h33;
                sign_mode = ~sign_mode;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < int'(BW)) begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                check({tag, "_nodone"}, 64'(done), 64'd0);
                check({tag, "_held"}, 64'(result), 64'(model_res));
            end else begin
                check({tag, "_done"}, 64'(done), 64'd1);
                check({tag, "_idlebusy"}, 64'(busy), 64'd0);
                check({tag, "_result"}, 64'(result), 64'(exp));
            end
        end
        model_res = exp;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_keep"}, 64'(result), 64'(model_res));
    endtask

    task automatic do_op(input string tag, input logic [AW-1:0] ta, input logic [BW-1:0] tb,
                         input logic ts, input logic tacc, input logic [31:0] exp,
                         input int poke);
        launch(ta, tb, ts, tacc);
        wait_done(tag, exp, poke);
        idle_check(tag);
    endtask

    initial begin
        logic saw_done;
        n_vec     = 0;
        n_err     = 0;
        model_res = '0;
        rst       = 1'b1;
        start     = 1'b0;
        sign_mode = 1'b0;
        a         = '0;
        b         = '0;
        acc       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("s_m3x5", 24'hFFFFFD, 8'h05, 1'b1, 1'b0, 32'hFFFFFFF1, 0);
        do_op("u_max", 24'hFFFFFF, 8'hFF, 1'b0, 1'b0, 32'hFEFFFF01, 0);
        do_op("s_m1xm1", 24'hFFFFFF, 8'hFF, 1'b1, 1'b0, 32'h00000001, 0);
        do_op("s_min", 24'h800000, 8'h80, 1'b1, 1'b0, 32'h40000000, 0);
        do_op("s_7xm3", 24'h000007, 8'hFD, 1'b1, 1'b0, 32'hFFFFFFEB, 0);
        do_op("u_shift", 24'h123456, 8'h10, 1'b0, 1'b0, 32'h01234560, 0);
        do_op("u_zero", 24'hABCDEF, 8'h00, 1'b0, 1'b0, 32'h00000000, 0);

        // start during RUN at E0+3 must not disturb the operation
        do_op("poke", 24'h000003, 8'h04, 1'b0, 1'b0, 32'h0000000C, 3);

        // back-to-back: start held in the DONE cycle launches the next product
        launch(24'h000009, 8'h0B, 1'b0, 1'b0);
        wait_done("b2b_a", 32'h00000063, 0);
        launch(24'hFFFFFE, 8'h03, 1'b1, 1'b0);
        wait_done("b2b_b", 32'hFFFFFFFA, 0);
        idle_check("b2b");

        // reset at E0+4 discards the partial product
        launch(24'h000005, 8'h06, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_res = '0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_pulse", 64'(saw_done), 64'd0);

`ifdef SEQ_MUL_ACC_EN
        do_op("acc0", 24'h000003, 8'h04, 1'b0, 1'b0, 32'h0000000C, 0);
        do_op("acc1", 24'h000002, 8'h05, 1'b0, 1'b1, 32'h00000016, 0);
        do_op("acc_neg", 24'hFFFFFF, 8'h01, 1'b1, 1'b1, 32'h00000015, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
